// File: rtl/snake_body_tracker_pkg.sv
// snake_body_tracker_pkg: grid constants, start-position defaults and FSM states shared by the body tracker
package snake_body_tracker_pkg;
    localparam int CW_DEF      = 5;
    localparam int CELL_SH_DEF = 4;
    localparam int GRID_W      = 640 >> CELL_SH_DEF;
    localparam int GRID_H      = 480 >> CELL_SH_DEF;
    localparam int INIT_X_DEF  = 6;
    localparam int INIT_Y_DEF  = 7;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK} state_t;
endpackage

// File: rtl/snake_seg_match.sv
// snake_seg_match: tells whether a scan cell coincides with one valid body segment
module snake_seg_match #(
    parameter int CW = 5
) (
    input  logic [CW-1:0] cx,
    input  logic [CW-1:0] cy,
    input  logic [CW-1:0] seg_x,
    input  logic [CW-1:0] seg_y,
    input  logic          valid,
    output logic          hit
);
    assign hit = valid && cx == seg_x && cy == seg_y;
endmodule

// File: rtl/snake_body_tracker.sv
// snake_body_tracker: ordered snake body (slot 0 = head) with step/grow shifting, a serial
// self-collision scan and a parallel per-pixel head/body lookup for the colour mux.
module snake_body_tracker
    import snake_body_tracker_pkg::*;
#(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 5,
    parameter int CW       = CW_DEF,
    parameter int CELL_SH  = CELL_SH_DEF,
    parameter int INIT_X   = INIT_X_DEF,
    parameter int INIT_Y   = INIT_Y_DEF
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           clear,
    input  logic                           step,
    input  logic                           grow,
    input  logic [CW-1:0]                  head_x,
    input  logic [CW-1:0]                  head_y,
    output logic                           step_ack,
    output logic                           busy,
    output logic                           check_done,
    output logic                           self_hit,
    output logic [$clog2(MAX_LEN+1)-1:0]   length,
    input  logic [9:0]                     pixel_x,
    input  logic [9:0]                     pixel_y,
    output logic                           head_on,
    output logic                           body_on
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(MAX_LEN);
    state_t          state_q, state_d;
    logic [CW-1:0]   slot_x_q [MAX_LEN], slot_x_d [MAX_LEN], init_x [MAX_LEN];
    logic [CW-1:0]   slot_y_q [MAX_LEN], slot_y_d [MAX_LEN], init_y [MAX_LEN];
    logic [LW-1:0]   length_q, length_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cap_x_q, cap_x_d, cap_y_q, cap_y_d;
    logic            grow_q, grow_d, self_hit_q, self_hit_d;
    logic            step_ack_q, step_ack_d, check_done_q, check_done_d;
    logic            head_on_q, head_on_d, body_on_q, body_on_d;
    logic [CW-1:0]   cx, cy;
    logic [MAX_LEN-1:0] hit;
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            init_x[i] = i < INIT_LEN ? CW'(INIT_X - i) : '0;
            init_y[i] = i < INIT_LEN ? CW'(INIT_Y) : '0;
        end
    end
    assign cx = CW'(pixel_x >> CELL_SH);
    assign cy = CW'(pixel_y >> CELL_SH);
    // Parallel lookup: every slot has its own comparator, masked by the current length.
    for (genvar g = 0; g < MAX_LEN; g++) begin : g_match
        snake_seg_match #(.CW(CW)) u_match (
            .cx    (cx),
            .cy    (cy),
            .seg_x (slot_x_q[g]),
            .seg_y (slot_y_q[g]),
            .valid ((g == 0) || (LW'(g) < length_q)),
            .hit   (hit[g])
        );
    end
    assign head_on_d = !clear && hit[0];
    assign body_on_d = !clear && |hit[MAX_LEN-1:1];
    always_comb begin
        state_d      = state_q;
        slot_x_d     = slot_x_q;
        slot_y_d     = slot_y_q;
        length_d     = length_q;
        idx_d        = idx_q;
        cap_x_d      = cap_x_q;
        cap_y_d      = cap_y_q;
        grow_d       = grow_q;
        self_hit_d   = self_hit_q;
        step_ack_d   = 1'b0;
        check_done_d = 1'b0;
        if (clear) begin
            state_d    = S_IDLE;
            slot_x_d   = init_x;
            slot_y_d   = init_y;
            length_d   = LW'(INIT_LEN);
            idx_d      = '0;
            cap_x_d    = '0;
            cap_y_d    = '0;
            grow_d     = 1'b0;
            self_hit_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (step) begin
                    step_ack_d = 1'b1;
                    cap_x_d    = head_x;
                    cap_y_d    = head_y;
                    grow_d     = grow;
                    state_d    = S_SHIFT;
                end
                S_SHIFT: begin
                    for (int i = 1; i < MAX_LEN; i++) begin
                        slot_x_d[i] = slot_x_q[i-1];
                        slot_y_d[i] = slot_y_q[i-1];
                    end
                    slot_x_d[0] = cap_x_q;
                    slot_y_d[0] = cap_y_q;
                    length_d    = (grow_q && length_q != LW'(MAX_LEN)) ? length_q + LW'(1) : length_q;
                    idx_d       = IW'(1);
                    state_d     = S_CHECK;
                end
                S_CHECK: begin
                    // One shared comparator walks the body against the new head.
                    self_hit_d = self_hit_q || (slot_x_q[idx_q] == slot_x_q[0] && slot_y_q[idx_q] == slot_y_q[0]);
                    if (LW'(idx_q) == length_q - LW'(1)) begin
                        check_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            slot_x_q     <= init_x;
            slot_y_q     <= init_y;
            length_q     <= LW'(INIT_LEN);
            idx_q        <= '0;
            cap_x_q      <= '0;
            cap_y_q      <= '0;
            grow_q       <= 1'b0;
            self_hit_q   <= 1'b0;
            step_ack_q   <= 1'b0;
            check_done_q <= 1'b0;
            head_on_q    <= 1'b0;
            body_on_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_x_q     <= slot_x_d;
            slot_y_q     <= slot_y_d;
            length_q     <= length_d;
            idx_q        <= idx_d;
            cap_x_q      <= cap_x_d;
            cap_y_q      <= cap_y_d;
            grow_q       <= grow_d;
            self_hit_q   <= self_hit_d;
            step_ack_q   <= step_ack_d;
            check_done_q <= check_done_d;
            head_on_q    <= head_on_d;
            body_on_q    <= body_on_d;
        end
    end
    assign step_ack   = step_ack_q;
    assign busy       = state_q != S_IDLE;
    assign check_done = check_done_q;
    assign self_hit   = self_hit_q;
    assign length     = length_q;
    assign head_on    = head_on_q;
    assign body_on    = body_on_q;
endmodule

// File: tb/tb_snake_body_tracker.sv
// tb_snake_body_tracker: directed steps against a slot-array model; expected step results and
// pixel answers are queued when driven and popped when the DUT answers.
module tb_snake_body_tracker;
    logic       clk = 1'b0;
    logic       reset_n, clear, step, grow;
    logic [4:0] head_x, head_y;
    logic       step_ack, busy, check_done, self_hit, head_on, body_on;
    logic [4:0] length;
    logic [9:0] pixel_x, pixel_y;
    int         total = 0, passed = 0;
    int         mx [16], my [16];
    int         mlen;
    bit         mhit;
    logic [5:0] res_q [$];
    logic [1:0] pix_q [$];

    snake_body_tracker dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .step(step), .grow(grow),
        .head_x(head_x), .head_y(head_y), .step_ack(step_ack), .busy(busy),
        .check_done(check_done), .self_hit(self_hit), .length(length),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .head_on(head_on), .body_on(body_on)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic init_model();
        for (int i = 0; i < 16; i++) begin
            mx[i] = i < 5 ? 6 - i : 0;
            my[i] = i < 5 ? 7 : 0;
        end
        mlen = 5;
        mhit = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_length"}, length, 5);
        check({tag, "_self_hit"}, self_hit, 0);
        check({tag, "_step_ack"}, step_ack, 0);
        check({tag, "_check_done"}, check_done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_head_on"}, head_on, 0);
        check({tag, "_body_on"}, body_on, 0);
    endtask

    task automatic query(input int cx, input int cy);
        logic hx, bx;
        logic [1:0] e;
        hx = (cx == mx[0] && cy == my[0]);
        bx = 1'b0;
        for (int i = 1; i < mlen; i++) if (cx == mx[i] && cy == my[i]) bx = 1'b1;
        pix_q.push_back({hx, bx});
        pixel_x = 10'(cx * 16 + $urandom_range(0, 15));
        pixel_y = 10'(cy * 16 + $urandom_range(0, 15));
        @(posedge clk); #1;
        e = pix_q.pop_front();
        check($sformatf("head_on(%0d,%0d)", cx, cy), head_on, e[1]);
        check($sformatf("body_on(%0d,%0d)", cx, cy), body_on, e[0]);
    endtask

    task automatic issue_step(input int hx, input int hy, input bit g);
        for (int i = 15; i > 0; i--) begin
            mx[i] = mx[i-1];
            my[i] = my[i-1];
        end
        mx[0] = hx;
        my[0] = hy;
        if (g && mlen < 16) mlen++;
        for (int i = 1; i < mlen; i++) if (mx[i] == hx && my[i] == hy) mhit = 1'b1;
        res_q.push_back({mhit, 5'(mlen)});
        head_x = 5'(hx);
        head_y = 5'(hy);
        grow = g;
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        check("step_ack", step_ack, 1);
        check("busy_after_ack", busy, 1);
    endtask

    task automatic finish_step(input int n0);
        int n;
        logic [5:0] e;
        n = n0;
        while (!check_done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        e = res_q.pop_front();
        check("check_done", check_done, 1);
        check("latency", n, mlen + 1);
        check("self_hit", self_hit, e[5]);
        check("length", length, e[4:0]);
        check("busy_idle", busy, 0);
    endtask

    task automatic do_step(input int hx, input int hy, input bit g);
        issue_step(hx, hy, g);
        finish_step(1);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        init_model();
    endtask

    initial begin
        int seen;
        reset_n = 1'b0; clear = 1'b0; step = 1'b0; grow = 1'b0;
        head_x = '0; head_y = '0; pixel_x = '0; pixel_y = '0;
        init_model();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset_n = 1'b1;
        // initial body and its boundaries
        query(6, 7); query(7, 7); query(3, 7); query(2, 7); query(1, 7);
        // plain step
        do_step(8, 7, 1'b0);
        query(8, 7); query(6, 7); query(3, 7); query(2, 7);
        // growth up to saturation and one beyond
        for (int k = 0; k < 12; k++) do_step(9 + k, 7, 1'b1);
        query(20, 7); query(5, 7); query(4, 7); query(3, 7);
        // square loop into own body
        pulse_clear();
        check_reset_state("clear1");
        do_step(6, 6, 1'b0); do_step(7, 6, 1'b0); do_step(7, 7, 1'b0); do_step(6, 7, 1'b0);
        check("hit_set", self_hit, 1);
        do_step(5, 7, 1'b0);
        check("hit_sticky", self_hit, 1);
        pulse_clear();
        check_reset_state("clear2");
        // step dropped while busy
        issue_step(9, 7, 1'b0);
        @(posedge clk); #1;
        head_x = 5'd20; head_y = 5'd20; step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        check("dropped_ack", step_ack, 0);
        finish_step(3);
        repeat (3) @(posedge clk);
        #1;
        check("no_second_ack", busy, 0);
        query(20, 20); query(9, 7); query(3, 7);
        // clear aborts the scan
        issue_step(10, 7, 1'b0);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        void'(res_q.pop_front());
        init_model();
        check("abort_busy", busy, 0);
        check("abort_length", length, 5);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (check_done) seen++;
            @(posedge clk); #1;
        end
        check("abort_no_done", seen, 0);
        query(6, 7); query(10, 7);
        // reset mid-scan
        do_step(6, 6, 1'b0);
        issue_step(7, 6, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        void'(res_q.pop_front());
        init_model();
        check_reset_state("midreset");
        do_step(8, 7, 1'b0);
        query(8, 7); query(2, 7);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
